tcu_priv_irq_ctrl: RTL and testbench

Privileged interrupt controller for the TCU. It is the receiving end of the valid/stall interrupt handshake driven by the privileged timer and other privileged interrupt sources. It latches each accepted request as a pending bit and delivers pending interrupts to the core one at a time on a level IRQ line with a cause index. It holds each interrupt until the core acknowledges it through a privileged register write.

---
 rtl/tcu_priv_irq_ctrl_pkg.sv | 13 +
 rtl/tcu_priv_irq_ctrl_prio_enc.sv | 23 ++
 rtl/tcu_priv_irq_ctrl.sv | 80 ++++++++
 tb/tb_tcu_priv_irq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcu_priv_irq_ctrl_pkg.sv
// rtl/tcu_priv_irq_ctrl_pkg.sv - shared TCU defines: interrupt source indices and controller FSM encodings
package tcu_priv_irq_ctrl_pkg;

    localparam int IRQ_SRC_TIMER = 0;
    localparam int IRQ_SRC_CORE  = 1;

    typedef enum logic [1:0] {
        S_IRQ_CTRL_IDLE    = 2'd0,
        S_IRQ_CTRL_ACTIVE  = 2'd1,
        S_IRQ_CTRL_HOLDOFF = 2'd2
    } irq_ctrl_state_e;

endpackage

// File: rtl/tcu_priv_irq_ctrl_prio_enc.sv
// rtl/tcu_priv_irq_ctrl_prio_enc.sv - fixed-priority encoder, lowest set index wins
module tcu_prio_enc #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    // Scan from the top down so the last hit written is the lowest index.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcu_priv_irq_ctrl.sv
// rtl/tcu_priv_irq_ctrl.sv - privileged interrupt controller: pending latch, one-at-a-time delivery, ack holdoff
module tcu_priv_irq_ctrl
    import tcu_priv_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC      = 2,
    parameter int SRC_IDX_SIZE = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_SRC-1:0]      src_irq_valid_i,
    output logic [NUM_SRC-1:0]      src_irq_stall_o,
    input  logic [NUM_SRC-1:0]      irq_enable_i,
    output logic                    core_irq_o,
    output logic [SRC_IDX_SIZE-1:0] core_irq_cause_o,
    input  logic                    core_irq_ack_i,
    output logic [NUM_SRC-1:0]      irq_pending_o
);

    irq_ctrl_state_e         r_state;
    logic [NUM_SRC-1:0]      r_pending;
    logic [SRC_IDX_SIZE-1:0] r_cause;

    logic [NUM_SRC-1:0]      w_accept;
    logic [NUM_SRC-1:0]      w_clear;
    logic [SRC_IDX_SIZE-1:0] w_sel_idx;
    logic                    w_sel_found;
    logic                    w_ack_taken;

    assign w_accept    = src_irq_valid_i & ~r_pending;
    assign w_ack_taken = (r_state == S_IRQ_CTRL_ACTIVE) && core_irq_ack_i;

    always_comb begin
        w_clear = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_clear[i] = w_ack_taken && (r_cause == SRC_IDX_SIZE'(i));
        end
    end

    tcu_prio_enc #(
        .N     (NUM_SRC),
        .IDX_W (SRC_IDX_SIZE)
    ) u_prio_enc (
        .i_req   (r_pending & irq_enable_i),
        .o_idx   (w_sel_idx),
        .o_found (w_sel_found)
    );

    // A source's own request in its ack cycle is blocked by the still-set pending bit,
    // so clear and set never target the same bit in one update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= S_IRQ_CTRL_IDLE;
            r_pending <= '0;
            r_cause   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_accept;
            case (r_state)
                S_IRQ_CTRL_IDLE: begin
                    if (w_sel_found) begin
                        r_state <= S_IRQ_CTRL_ACTIVE;
                        r_cause <= w_sel_idx;
                    end
                end
                S_IRQ_CTRL_ACTIVE: begin
                    if (core_irq_ack_i) begin
                        r_state <= S_IRQ_CTRL_HOLDOFF;
                    end
                end
                S_IRQ_CTRL_HOLDOFF: r_state <= S_IRQ_CTRL_IDLE;
                default:            r_state <= S_IRQ_CTRL_IDLE;
            endcase
        end
    end

    assign src_irq_stall_o  = r_pending;
    assign irq_pending_o    = r_pending;
    assign core_irq_o       = (r_state == S_IRQ_CTRL_ACTIVE);
    assign core_irq_cause_o = r_cause;

endmodule

// File: tb/tb_tcu_priv_irq_ctrl.sv
// tb/tb_tcu_priv_irq_ctrl.sv - self-checking bench for tcu_priv_irq_ctrl
module tb_tcu_priv_irq_ctrl;

    logic       clk;
    logic       reset_i;
    logic [1:0] src_irq_valid_i;
    logic [1:0] src_irq_stall_o;
    logic [1:0] irq_enable_i;
    logic       core_irq_o;
    logic [0:0] core_irq_cause_o;
    logic       core_irq_ack_i;
    logic [1:0] irq_pending_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [0:0] sb[$];
    logic [0:0] mon_exp;
    logic       mon_prev = 1'b0;

    tcu_priv_irq_ctrl #(.NUM_SRC(2), .SRC_IDX_SIZE(1)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .src_irq_valid_i  (src_irq_valid_i),
        .src_irq_stall_o  (src_irq_stall_o),
        .irq_enable_i     (irq_enable_i),
        .core_irq_o       (core_irq_o),
        .core_irq_cause_o (core_irq_cause_o),
        .core_irq_ack_i   (core_irq_ack_i),
        .irq_pending_o    (irq_pending_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each rising edge of core_irq_o consumes the next expected cause.
    always @(negedge clk) begin
        if (core_irq_o === 1'b1 && mon_prev !== 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_cause: irq raised with cause %0d, expected no delivery", core_irq_cause_o);
            end else begin
                mon_exp = sb.pop_front();
                if (core_irq_cause_o !== mon_exp) begin
                    n_err++;
                    $display("FAIL sb_cause: got %0d expected %0d", core_irq_cause_o, mon_exp);
                end
            end
        end
        mon_prev = core_irq_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        src_irq_valid_i = 2'b11;
        irq_enable_i = 2'b11;
        core_irq_ack_i = 1'b0;
        tick();
        tick();
        n_cmp++; if (core_irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", core_irq_o); end
        n_cmp++; if (irq_pending_o !== 2'b00) begin n_err++; $display("FAIL reset_pending: got %b expected 00", irq_pending_o); end
        n_cmp++; if (src_irq_stall_o !== 2'b00) begin n_err++; $display("FAIL reset_stall: got %b expected 00", src_irq_stall_o); end
        reset_i = 1'b0;
        src_irq_valid_i = 2'b00;
        tick();
    endtask

    task automatic test_single();
        irq_enable_i = 2'b11;
        src_irq_valid_i = 2'b01;
        sb.push_back(1'b0);
        tick();
        n_cmp++; if (src_irq_stall_o !== 2'b01) begin n_err++; $display("FAIL single_stall: got %b expected 01", src_irq_stall_o); end
        n_cmp++; if (core_irq_o !== 1'b0) begin n_err++; $display("FAIL single_irq_c1: got %b expected 0", core_irq_o); end
        src_irq_valid_i = 2'b00;
        tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL single_irq_c2: got %b expected 1", core_irq_o); end
        tick(); tick(); tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL single_irq_held: got %b expected 1", core_irq_o); end
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        n_cmp++; if (core_irq_o !== 1'b0) begin n_err++; $display("FAIL single_irq_ack: got %b expected 0", core_irq_o); end
        n_cmp++; if (src_irq_stall_o !== 2'b00) begin n_err++; $display("FAIL single_stall_ack: got %b expected 00", src_irq_stall_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        src_irq_valid_i = 2'b11;
        sb.push_back(1'b0);
        sb.push_back(1'b1);
        tick();
        n_cmp++; if (src_irq_stall_o !== 2'b11) begin n_err++; $display("FAIL b2b_stall: got %b expected 11", src_irq_stall_o); end
        src_irq_valid_i = 2'b00;
        tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL b2b_first: got %b expected 1", core_irq_o); end
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        n_cmp++; if (core_irq_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap1: got %b expected 0", core_irq_o); end
        n_cmp++; if (irq_pending_o !== 2'b10) begin n_err++; $display("FAIL b2b_pending: got %b expected 10", irq_pending_o); end
        tick();
        n_cmp++; if (core_irq_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap2: got %b expected 0", core_irq_o); end
        tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL b2b_second: got %b expected 1", core_irq_o); end
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        tick();
        n_cmp++; if (irq_pending_o !== 2'b00) begin n_err++; $display("FAIL b2b_drained: got %b expected 00", irq_pending_o); end
    endtask

    task automatic test_masked();
        logic seen;
        irq_enable_i = 2'b01;
        src_irq_valid_i = 2'b10;
        sb.push_back(1'b1);
        tick();
        src_irq_valid_i = 2'b00;
        for (int i = 0; i < 20; i++) begin
            n_cmp++; if (core_irq_o !== 1'b0 || irq_pending_o !== 2'b10) begin
                n_err++; $display("FAIL masked_hold: cycle %0d irq %b pending %b expected 0/10", i, core_irq_o, irq_pending_o);
            end
            tick();
        end
        irq_enable_i = 2'b11;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            tick();
            seen = core_irq_o;
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL masked_release: irq %b expected 1 within 2 cycles", seen); end
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        tick();
    endtask

    task automatic test_spurious_ack();
        irq_enable_i = 2'b01;
        src_irq_valid_i = 2'b10;
        tick();
        src_irq_valid_i = 2'b00;
        tick();
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        n_cmp++; if (irq_pending_o !== 2'b10 || core_irq_o !== 1'b0) begin
            n_err++; $display("FAIL spur_idle: pending %b irq %b expected 10/0", irq_pending_o, core_irq_o);
        end
        irq_enable_i = 2'b11;
        sb.push_back(1'b1);
        sb.push_back(1'b0);
        tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL spur_active: got %b expected 1", core_irq_o); end
        src_irq_valid_i = 2'b01;
        tick();
        src_irq_valid_i = 2'b00;
        n_cmp++; if (irq_pending_o !== 2'b11) begin n_err++; $display("FAIL spur_both: got %b expected 11", irq_pending_o); end
        core_irq_ack_i = 1'b1;
        tick();
        n_cmp++; if (core_irq_o !== 1'b0 || irq_pending_o !== 2'b01) begin
            n_err++; $display("FAIL spur_holdoff: irq %b pending %b expected 0/01", core_irq_o, irq_pending_o);
        end
        tick();
        core_irq_ack_i = 1'b0;
        n_cmp++; if (core_irq_o !== 1'b0 || irq_pending_o !== 2'b01) begin
            n_err++; $display("FAIL spur_after_holdoff: irq %b pending %b expected 0/01", core_irq_o, irq_pending_o);
        end
        tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL spur_next: got %b expected 1", core_irq_o); end
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_ack_same_src();
        irq_enable_i = 2'b11;
        src_irq_valid_i = 2'b01;
        sb.push_back(1'b0);
        sb.push_back(1'b0);
        tick();
        src_irq_valid_i = 2'b00;
        tick();
        core_irq_ack_i = 1'b1;
        src_irq_valid_i = 2'b01;
        tick();
        core_irq_ack_i = 1'b0;
        n_cmp++; if (irq_pending_o !== 2'b00 || src_irq_stall_o !== 2'b00 || core_irq_o !== 1'b0) begin
            n_err++; $display("FAIL same_ack1: pending %b stall %b irq %b expected 00/00/0", irq_pending_o, src_irq_stall_o, core_irq_o);
        end
        tick();
        src_irq_valid_i = 2'b00;
        n_cmp++; if (irq_pending_o !== 2'b01) begin n_err++; $display("FAIL same_ack2: got %b expected 01", irq_pending_o); end
        tick();
        n_cmp++; if (core_irq_o !== 1'b1) begin n_err++; $display("FAIL same_ack3: got %b expected 1", core_irq_o); end
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        irq_enable_i = 2'b11;
        src_irq_valid_i = 2'b11;
        sb.push_back(1'b0);
        tick();
        tick();
        n_cmp++; if (core_irq_o !== 1'b1 || irq_pending_o !== 2'b11) begin
            n_err++; $display("FAIL rmid_pre: irq %b pending %b expected 1/11", core_irq_o, irq_pending_o);
        end
        reset_i = 1'b1;
        tick();
        n_cmp++; if (core_irq_o !== 1'b0 || irq_pending_o !== 2'b00 || src_irq_stall_o !== 2'b00) begin
            n_err++; $display("FAIL rmid_reset: irq %b pending %b stall %b expected 0/00/00", core_irq_o, irq_pending_o, src_irq_stall_o);
        end
        tick();
        n_cmp++; if (irq_pending_o !== 2'b00) begin n_err++; $display("FAIL rmid_noaccept: got %b expected 00", irq_pending_o); end
        reset_i = 1'b0;
        sb.push_back(1'b0);
        sb.push_back(1'b1);
        tick();
        src_irq_valid_i = 2'b00;
        n_cmp++; if (irq_pending_o !== 2'b11) begin n_err++; $display("FAIL rmid_reaccept: got %b expected 11", irq_pending_o); end
        tick();
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        tick();
        tick();
        core_irq_ack_i = 1'b1;
        tick();
        core_irq_ack_i = 1'b0;
        tick();
        n_cmp++; if (irq_pending_o !== 2'b00) begin n_err++; $display("FAIL rmid_drained: got %b expected 00", irq_pending_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_masked();
        test_spurious_ack();
        test_ack_same_src();
        test_reset_mid();
        tick();
        n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL sb_leftover: %0d expected deliveries never seen", sb.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
